// File: rtl/fib_pkg.sv
// Shared types for the Fibonacci pair serializer slice.
package fib_pkg;

  localparam int unsigned FIB_W = 16;

  typedef logic [FIB_W-1:0] fib_word_t;

  typedef struct packed {
    fib_word_t lo;
    fib_word_t hi;
  } fib_pair_t;

endpackage

// File: rtl/fib_pair_fifo.sv
// Synchronous pair FIFO with power-of-two depth and occupancy count.
module fib_pair_fifo
  import fib_pkg::*;
#(
  parameter type         T     = fib_pair_t,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  T                         din,
  output T                         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned LW = $clog2(DEPTH);

  T              mem [DEPTH];
  logic [LW-1:0] wr_ptr;
  logic [LW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == (LW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fib_pair_serializer.sv
// Buffers (lo,hi) word pairs and emits them one word at a time, flagging
// any word that is numerically below the previously accepted one.
module fib_pair_serializer
  import fib_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_lo,
  input  logic [W-1:0]             in_hi,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_data,
  output logic                     out_wrap,
  output logic [$clog2(DEPTH):0]   level
);

  localparam logic PH_LO = 1'b0;
  localparam logic PH_HI = 1'b1;

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
  } pair_t;

  pair_t        head;
  pair_t        tail_in;
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  logic         accept;
  logic         phase;
  logic [W-1:0] prev;
  logic         prev_valid;

  assign tail_in   = '{lo: in_lo, hi: in_hi};
  assign in_ready  = !full && rst;
  assign push      = in_valid && in_ready;
  assign out_valid = !empty;
  assign accept    = out_valid && out_ready;
  assign pop       = accept && (phase == PH_HI);
  assign out_data  = (phase == PH_HI) ? head.hi : head.lo;
  assign out_wrap  = out_valid && prev_valid && (out_data < prev);

  fib_pair_fifo #(
    .T     (pair_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (tail_in),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase      <= PH_LO;
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (accept) begin
      phase      <= ~phase;
      prev       <= out_data;
      prev_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fib_pair_serializer.sv
// Directed self-checking bench for fib_pair_serializer (W=16, DEPTH=4).
module tb_fib_pair_serializer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_lo;
  logic [15:0] in_hi;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_wrap;
  logic [2:0]  level;

  int unsigned n_checks;
  int unsigned n_fail;

  logic [15:0] plo [8];
  logic [15:0] phi [8];
  logic        pwrap [16];

  fib_pair_serializer #(
    .W     (16),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_lo     (in_lo),
    .in_hi     (in_hi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_wrap  (out_wrap),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push np pairs back-to-back with out_ready=1 and check the 2*np words.
  task automatic stream(input int np);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_lo     = plo[0];
    in_hi     = phi[0];
    for (int i = 0; i < 2*np; i++) begin
      step();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_data", 32'(out_data), 32'(((i % 2) == 0) ? plo[i/2] : phi[i/2]));
      check("stream_wrap", 32'(out_wrap), 32'(pwrap[i]));
      if (i + 1 < np) begin
        in_lo = plo[i+1];
        in_hi = phi[i+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    step();
    check("stream_empty", 32'(out_valid), 32'd0);
    check("stream_level", 32'(level), 32'd0);
    check("stream_nowrap", 32'(out_wrap), 32'd0);
  endtask

  initial begin
    logic [15:0] bp_exp [7];
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_lo     = '0;
    in_hi     = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) pwrap[i] = 1'b0;

    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_wrap", 32'(out_wrap), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_release_in_ready", 32'(in_ready), 32'd1);

    // Streaming: (1,1),(2,3),(5,8)
    plo[0] = 16'd1; phi[0] = 16'd1;
    plo[1] = 16'd2; phi[1] = 16'd3;
    plo[2] = 16'd5; phi[2] = 16'd8;
    stream(3);

    // Backpressure fill to full; head lo must hold.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    plo[0] = 16'd13;  phi[0] = 16'd21;
    plo[1] = 16'd34;  phi[1] = 16'd55;
    plo[2] = 16'd89;  phi[2] = 16'd144;
    plo[3] = 16'd233; phi[3] = 16'd377;
    for (int i = 0; i < 4; i++) begin
      in_lo = plo[i];
      in_hi = phi[i];
      step();
      check("bp_hold_data", 32'(out_data), 32'd13);
      check("bp_hold_wrap", 32'(out_wrap), 32'd0);
      check("bp_level", 32'(level), 32'(i + 1));
    end
    check("bp_full_in_ready", 32'(in_ready), 32'd0);
    step();
    check("bp_stable_data", 32'(out_data), 32'd13);

    // Full with an offered pair: LO accept, HI accept (pop), then push.
    in_valid  = 1'b1;
    in_lo     = 16'd610;
    in_hi     = 16'd987;
    out_ready = 1'b1;
    step();
    check("full_lo_level", 32'(level), 32'd4);
    check("full_lo_data", 32'(out_data), 32'd21);
    step();
    check("full_hi_level", 32'(level), 32'd3);
    check("full_hi_in_ready", 32'(in_ready), 32'd1);
    check("full_hi_data", 32'(out_data), 32'd34);
    step();
    check("full_push_level", 32'(level), 32'd4);
    check("full_push_data", 32'(out_data), 32'd55);
    in_valid = 1'b0;
    bp_exp[0] = 16'd89;  bp_exp[1] = 16'd144; bp_exp[2] = 16'd233;
    bp_exp[3] = 16'd377; bp_exp[4] = 16'd610; bp_exp[5] = 16'd987;
    for (int i = 0; i < 6; i++) begin
      step();
      check("drain_data", 32'(out_data), 32'(bp_exp[i]));
      check("drain_wrap", 32'(out_wrap), 32'd0);
    end
    step();
    check("drain_empty", 32'(out_valid), 32'd0);
    check("drain_level", 32'(level), 32'd0);

    // Wrap: 9489 follows 46368.
    plo[0] = 16'd28657; phi[0] = 16'd46368;
    plo[1] = 16'd9489;  phi[1] = 16'd55857;
    pwrap[2] = 1'b1;
    stream(2);
    pwrap[2] = 1'b0;

    // Reset mid-pair: lo=2 accepted, then reset discards hi.
    in_valid = 1'b1;
    in_lo    = 16'd2;
    in_hi    = 16'd3;
    step();
    in_valid = 1'b0;
    check("mid_lo_data", 32'(out_data), 32'd2);
    check("mid_lo_wrap", 32'(out_wrap), 32'd1);
    step();
    check("mid_hi_data", 32'(out_data), 32'd3);
    out_ready = 1'b0;
    rst = 1'b0;
    step();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_wrap", 32'(out_wrap), 32'd0);
    rst = 1'b1;
    plo[0] = 16'd1; phi[0] = 16'd1;
    stream(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fib_pair_serializer.md
FIB_PAIR_SERIALIZER -- requirements
Module: fib_pair_serializer

Interface
REQ-001 SHALL have parameter W, default 16, the width of one sequence word.
REQ-002 SHALL have parameter DEPTH, default 4, the pair-buffer capacity in pairs; a power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit, meaning the upstream pair is valid.
REQ-006 SHALL have port in_ready, output, 1 bit, meaning the buffer can accept a pair.
REQ-007 SHALL have port in_lo, input, W bits, the earlier word of the pair (first emitted).
REQ-008 SHALL have port in_hi, input, W bits, the later word of the pair (second emitted).
REQ-009 SHALL have port out_valid, output, 1 bit, meaning out_data is valid.
REQ-010 SHALL have port out_ready, input, 1 bit, meaning downstream accepts the word.
REQ-011 SHALL have port out_data, output, W bits, the serialized word.
REQ-012 SHALL have port out_wrap, output, 1 bit; high when out_data is unsigned-less-than the last accepted word.
REQ-013 SHALL have port level, output, log2(DEPTH)+1 bits, the number of pairs held.

Function
REQ-014 Push SHALL occur on a cycle with in_valid=1 and in_ready=1; {in_lo,in_hi} is stored at the tail.
REQ-015 Pop SHALL occur on the cycle out_valid=1, out_ready=1 and phase=HI; the head pair is removed.
REQ-016 in_ready SHALL equal (level != DEPTH) and rst=1; it SHALL NOT depend on out_ready, so a pop on a full buffer frees the slot only on the next cycle.
REQ-017 out_valid SHALL equal (level != 0); there SHALL be no same-cycle input-to-output bypass, so minimum latency is push at edge N, word visible after edge N.
REQ-018 A 1-bit phase register SHALL select the word: LO gives out_data=head.lo and HI gives out_data=head.hi.
REQ-019 The phase register SHALL toggle on every accepted output word.
REQ-020 While out_valid=1 and out_ready=0, out_data and out_wrap SHALL hold stable.
REQ-021 Simultaneous push and pop SHALL leave level unchanged, with both pointers advancing; pointers wrap modulo DEPTH.
REQ-022 A push with level=DEPTH SHALL be impossible.
REQ-023 in_lo and in_hi SHALL be ignored when no push occurs.
REQ-024 out_wrap SHALL equal prev_valid && (out_data < prev); prev and prev_valid SHALL update on every accepted word.
REQ-025 out_wrap SHALL be 0 whenever out_valid=0.
REQ-026 Arithmetic SHALL be unsigned, W bits; no saturation, and data SHALL pass through unmodified.

Reset
REQ-027 With rst=0 at a clock edge, after that edge: level=0, both pointers 0, phase=LO, prev_valid=0, prev=0.
REQ-028 Outputs during and after reset SHALL be: out_valid=0, out_wrap=0, in_ready=0 while rst=0, and in_ready=1 on the first cycle with rst=1.
REQ-029 Reset mid-operation SHALL discard all buffered pairs and any half-emitted pair without emitting further words.
REQ-030 Buffer storage SHALL need no reset; out_data SHALL be don't-care while out_valid=0.

Structure
REQ-031 Package fib_pkg SHALL hold: localparam FIB_W=16, typedef fib_word_t (logic [FIB_W-1:0]), and typedef struct packed fib_pair_t {lo, hi}.
REQ-032 The pair buffer SHALL be the sub-module fib_pair_fifo: a synchronous FIFO of fib_pair_t with push, pop, full, empty and level.
REQ-033 Phase, serialization and wrap detection SHALL live in the top module.

Verification
REQ-034 Streaming: push (1,1),(2,3),(5,8) on consecutive cycles with out_ready=1 -> out_data 1,1,2,3,5,8 on 6 consecutive cycles, out_wrap=0, level returns to 0.
REQ-035 Backpressure: out_ready=0 and push 4 pairs -> level=4, in_ready=0, out_data=first lo held stable; raise out_ready -> all 8 words in order.
REQ-036 Full with simultaneous events: at level=4, in_valid=1, accept HI -> level=3 after the edge, no push that cycle, push on the next cycle.
REQ-037 Wrap: push (28657,46368),(9489,55857) -> out_wrap=1 only on 9489.
REQ-038 Reset mid-pair: after lo=2 of (2,3) is accepted, rst=0 for 1 cycle -> out_valid=0, level=0; the next pushed (1,1) emits lo first with out_wrap=0.
